exception_ctrl_unit: RTL
========================

EXCEPTION_CTRL_UNIT -- requirements
Module: exception_ctrl_unit

Interface
REQ-001 Parameter PC_W, default 32, width of all PC ports and the EPC.
REQ-002 Parameter OPC_W, default 7, width of ID_opcode.
REQ-003 Parameter HANDLER_ADDR, default 32'h0000_0100, PC driven on redirect.
REQ-004 Parameter CNT_W, default 8, width of the dropped-exception counter.
REQ-005 clk  in  1  single clock; all state updates on negedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ID_PC, EX_PC, MEM_PC  in  PC_W  PC of the instruction in each stage.
REQ-008 ID_opcode  in  OPC_W  opcode of the ID-stage instruction.
REQ-009 ID_valid  in  1  ID holds a real instruction (0 = bubble).
REQ-010 EX_ovf  in  1  qualified signed-overflow flag from EX.
REQ-011 MEM_misalign  in  1  qualified misaligned lw/sw address from MEM.
REQ-012 eret  in  1  handler-return pulse.
REQ-013 excep_flag, id_flush, EX_FLUSH, MEM_FLUSH  out  1  exception-active flag and per-stage flushes.
REQ-014 redirect_valid  out  1 / redirect_pc  out  PC_W  fetch-redirect request and target.
REQ-015 epc  out  PC_W / cause  out  2  PC of the faulting instruction and its cause code.
REQ-016 dropped_cnt  out  CNT_W  exceptions ignored while the handler was active.

Function
REQ-017 Cause codes: 0 = none, 1 = illegal opcode (ID), 2 = overflow (EX), 3 = misaligned access (MEM).
REQ-018 ID opcode is illegal only when ID_valid = 1 and the opcode is outside the package legal-opcode table (24 ISA opcodes plus hlt 7'h7F).
REQ-019 Source priority, oldest first: MEM > EX > ID; only the highest-priority source is taken in a cycle.
REQ-020 FSM states: IDLE, FLUSH, REDIRECT, HANDLER.
REQ-021 IDLE: on a detected exception, epc and cause latch the winning stage's PC and code, and the FSM moves to FLUSH; with no exception it stays in IDLE.
REQ-022 FLUSH lasts exactly 1 cycle.
REQ-023 In FLUSH, the faulting stage and all younger stages flush: MEM cause -> all three flushes; EX cause -> id_flush and EX_FLUSH; ID cause -> id_flush only.
REQ-024 REDIRECT lasts exactly 1 cycle: redirect_valid = 1, redirect_pc = HANDLER_ADDR; otherwise redirect_pc = 0.
REQ-025 HANDLER holds until eret = 1, then the FSM returns to IDLE.
REQ-026 excep_flag = 1 in FLUSH, REDIRECT and HANDLER, and 0 in IDLE.
REQ-027 In FLUSH, REDIRECT or HANDLER, a detected exception does not change epc or cause; dropped_cnt increments, saturating at all-ones.
REQ-028 eret outside HANDLER is ignored.
REQ-029 When eret and a new exception coincide in HANDLER, the FSM returns to IDLE and the exception counts as dropped.
REQ-030 epc and cause hold their values after return to IDLE until the next taken exception.
REQ-031 Detection-to-first-flush latency is 1 clock edge.

Reset
REQ-032 rst = 1 forces the state to IDLE immediately, at any point including mid-FLUSH or mid-HANDLER.
REQ-033 rst = 1 forces every output, epc, cause and dropped_cnt to 0.
REQ-034 After rst deasserts, the first detection is evaluated at the next negedge clk.

Configuration
REQ-035 Macro EXCEP_OVERFLOW_EN: when defined, EX_ovf is a cause source (code 2).
REQ-036 When EXCEP_OVERFLOW_EN is undefined, EX_ovf is ignored, code 2 is never produced, and the port remains present.

Structure
REQ-037 The shared package holds the cause-code constants, the FSM state enum, the legal-opcode constants and HANDLER_ADDR's default.
REQ-038 The sub-module opcode_legal_chk is a combinational legality lookup on the opcode only; the FSM, latches and counter stay in the top.

Verification
REQ-039 Scenario: ID_opcode = 7'h20, ID_valid = 1 -> no exception; ID_opcode = 7'h7F -> no exception.
REQ-040 Scenario: ID_opcode = 7'h11, ID_valid = 1, ID_PC = 32'h40 -> id_flush for 1 cycle, then redirect_pc = 32'h100 for 1 cycle, epc = 32'h40, cause = 1, excep_flag held until eret.
REQ-041 Scenario: same-cycle MEM_misalign with MEM_PC = 32'h38, EX_ovf, and illegal ID -> cause = 3, epc = 32'h38, all three flushes for 1 cycle.
REQ-042 Scenario: 300 EX_ovf pulses during HANDLER -> dropped_cnt = 255, epc unchanged.
REQ-043 Scenario: eret and MEM_misalign in the same HANDLER cycle -> IDLE, dropped_cnt + 1.
REQ-044 Scenario: rst asserted mid-REDIRECT -> all outputs 0 without waiting for a clock edge.
REQ-045 Scenario: with EXCEP_OVERFLOW_EN undefined, an EX_ovf pulse -> no flush.

Source files
------------

// File: rtl/exception_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// exception_ctrl_unit_pkg
// Shared definitions for the exception control unit:
//   - cause codes reported on the cause output
//   - FSM state encoding
//   - table of legal opcodes (24 ISA opcodes plus hlt)
//   - default handler entry address
// -----------------------------------------------------------------------------
package exception_ctrl_unit_pkg;

    // Cause codes, oldest pipeline stage has the highest code
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;  // illegal opcode in ID
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;  // signed overflow in EX
    localparam logic [1:0] CAUSE_MISALIGN = 2'd3;  // misaligned lw/sw in MEM

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HANDLER  = 2'd3
    } state_e;

    // Legal ISA opcodes: three groups of eight
    localparam int         NUM_LEGAL_OPC = 24;
    localparam logic [6:0] LEGAL_OPC [NUM_LEGAL_OPC] = '{
        7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
        7'h20, 7'h21, 7'h22, 7'h23, 7'h24, 7'h25, 7'h26, 7'h27,
        7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37
    };
    localparam logic [6:0] OPC_HLT = 7'h7F;

    localparam logic [31:0] HANDLER_ADDR_DFLT = 32'h0000_0100;

endpackage

// File: rtl/exception_ctrl_unit_opcode_legal_chk.sv
// -----------------------------------------------------------------------------
// opcode_legal_chk
// Combinational lookup: is the opcode a member of the legal-opcode table?
// Ports:
//   opcode_i  in  OPC_W  opcode to classify
//   legal_o   out 1      1 = opcode is in the table (or is hlt)
// -----------------------------------------------------------------------------
module opcode_legal_chk
    import exception_ctrl_unit_pkg::*;
#(
    parameter int OPC_W = 7
) (
    input  logic [OPC_W-1:0] opcode_i,
    output logic             legal_o
);

    always_comb begin
        legal_o = (opcode_i == OPC_W'(OPC_HLT));
        for (int i = 0; i < NUM_LEGAL_OPC; i++) begin
            if (opcode_i == OPC_W'(LEGAL_OPC[i])) begin
                legal_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exception_ctrl_unit.sv
// -----------------------------------------------------------------------------
// exception_ctrl_unit
// Detects pipeline exceptions (illegal ID opcode, EX overflow, MEM misalign),
// records the faulting PC and cause, flushes the faulting and younger stages,
// redirects fetch to the handler and waits for eret. Exceptions arriving while
// a handler is in progress are counted (saturating) and otherwise ignored.
// State updates on the falling clock edge; rst is asynchronous, active high.
//
// Configuration macro:
//   EXCEP_OVERFLOW_EN  defined   -> EX_ovf raises cause 2
//                      undefined -> EX_ovf is ignored (port still present)
//
// Ports:
//   clk, rst                       clock (negedge active), async reset
//   ID_PC, EX_PC, MEM_PC    in     PC of the instruction in each stage
//   ID_opcode, ID_valid     in     ID opcode and valid (0 = bubble)
//   EX_ovf                  in     qualified signed overflow from EX
//   MEM_misalign            in     qualified misaligned access from MEM
//   eret                    in     handler-return pulse
//   excep_flag              out    exception in progress
//   id_flush/EX_FLUSH/MEM_FLUSH out per-stage flush
//   redirect_valid/redirect_pc out fetch redirect to HANDLER_ADDR
//   epc, cause              out    faulting PC and cause code
//   dropped_cnt             out    exceptions ignored while busy (saturating)
// -----------------------------------------------------------------------------
module exception_ctrl_unit
    import exception_ctrl_unit_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter int              OPC_W        = 7,
    parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(HANDLER_ADDR_DFLT),
    parameter int              CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  ID_PC,
    input  logic [PC_W-1:0]  EX_PC,
    input  logic [PC_W-1:0]  MEM_PC,
    input  logic [OPC_W-1:0] ID_opcode,
    input  logic             ID_valid,
    input  logic             EX_ovf,
    input  logic             MEM_misalign,
    input  logic             eret,
    output logic             excep_flag,
    output logic             id_flush,
    output logic             EX_FLUSH,
    output logic             MEM_FLUSH,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [PC_W-1:0]  epc,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] dropped_cnt
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    epc_q, epc_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic               opc_legal;
    logic               id_exc, ex_exc;
    logic [1:0]         win_cause;
    logic [PC_W-1:0]    win_pc;

    opcode_legal_chk #(.OPC_W(OPC_W)) u_legal_chk (
        .opcode_i (ID_opcode),
        .legal_o  (opc_legal)
    );

    assign id_exc = ID_valid & ~opc_legal;

`ifdef EXCEP_OVERFLOW_EN
    assign ex_exc = EX_ovf;
`else
    // Overflow source disabled; the port is still read so it is not dangling.
    assign ex_exc = EX_ovf & 1'b0;
`endif

    // Oldest stage wins: MEM > EX > ID
    always_comb begin
        win_cause = CAUSE_NONE;
        win_pc    = '0;
        if (MEM_misalign) begin
            win_cause = CAUSE_MISALIGN;
            win_pc    = MEM_PC;
        end else if (ex_exc) begin
            win_cause = CAUSE_OVERFLOW;
            win_pc    = EX_PC;
        end else if (id_exc) begin
            win_cause = CAUSE_ILLEGAL;
            win_pc    = ID_PC;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        drop_d         = drop_q;
        excep_flag     = 1'b0;
        id_flush       = 1'b0;
        EX_FLUSH       = 1'b0;
        MEM_FLUSH      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_cause != CAUSE_NONE) begin
                    state_d = ST_FLUSH;
                    epc_d   = win_pc;
                    cause_d = win_cause;
                end
            end
            ST_FLUSH: begin
                excep_flag = 1'b1;
                // Faulting stage and every younger stage are flushed
                id_flush   = 1'b1;
                EX_FLUSH   = (cause_q == CAUSE_OVERFLOW) || (cause_q == CAUSE_MISALIGN);
                MEM_FLUSH  = (cause_q == CAUSE_MISALIGN);
                state_d    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                excep_flag     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = HANDLER_ADDR;
                state_d        = ST_HANDLER;
            end
            ST_HANDLER: begin
                excep_flag = 1'b1;
                if (eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any exception seen while busy is dropped, including one that
        // coincides with eret.
        if ((state_q != ST_IDLE) && (win_cause != CAUSE_NONE) && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= CAUSE_NONE;
            drop_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            drop_q  <= drop_d;
        end
    end

    assign epc         = epc_q;
    assign cause       = cause_q;
    assign dropped_cnt = drop_q;

endmodule
